risc16p: RTL and testbench
==========================

RISC16P -- requirements
Module: risc16p

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk input 1 (rising edge); rst input 1, synchronous, active-high.
REQ-002 The instruction port SHALL be: iaddr output 16 (byte address); idin input 16 (instruction, valid combinationally); ioe output 1 (instruction read enable).
REQ-003 The data port SHALL be: daddr output 16; ddout output 16 (store data); ddin input 16 (load data, combinational); doe output 1 (read enable); dwe output 1 (write enable).
REQ-004 Memory SHALL be treated as byte-addressed, big-endian (high byte at the even address), with word-only accesses; address bit 0 is ignored.

Function
REQ-005 Eight 16-bit general registers r0..r7 SHALL exist, in a reg_file_inst submodule named register0..register7; r0 is an ordinary register.
REQ-006 Instruction format SHALL be: op=[15:11], Rd=[10:8], Rs=[7:5], func=[4:0], imm8=[7:0], imm11=[10:0].
REQ-007 For op 00000 the func field SHALL select the operation:
- 00000 NOP; 00001 MV Rd=Rs; 00010 NOT Rd=~Rs; 00011 XOR Rd^=Rs
- 00100 ADD Rd+=Rs; 00101 SUB Rd-=Rs
- 01000 SL8 Rd=Rs<<8; 01001 SR8 Rd=Rs>>8; 01100 SL Rd=Rs<<1; 01101 SR Rd=Rs>>1 (all logical)
- 10000 AND; 10001 OR
- 10100 ST mem[Rs]=Rd; 10101 LD Rd=mem[Rs]
REQ-008 Immediate ops SHALL be: 00100 ADDI Rd+=sext(imm8); 00110 ANDI Rd&=zext(imm8); 00111 ORI Rd|=zext(imm8); 00001 LLI Rd=zext(imm8); 00010 LUI Rd={imm8,8'h00}.
REQ-009 Control ops SHALL be: 11000 BNEZ; 11001 BEQZ; 11010 BMI (Rd[15]=1); 11011 BPL (Rd[15]=0). Branch target = branch PC + 2 + sext(imm8). 11100 J, target = PC + 2 + sext(imm11).
REQ-010 Undefined opcodes/funcs SHALL execute as NOP; all arithmetic is 16-bit modulo 2^16, with no flags.
REQ-011 Pipeline SHALL be IF/RF/EX/WB, one instruction per cycle; registers:
- IF: if_pc; latches if_ir<=idin and rf_pc<=if_pc.
- RF: latches rf_ir, rf_treg1 (Rd value), rf_treg2 (Rs value), rf_immediate (extended imm), and the PC.
- EX: latches ex_ir<=rf_ir and ex_result.
REQ-012 iaddr SHALL equal if_pc, and ioe SHALL be 1 whenever rst=0.
REQ-013 In EX, the ALU SHALL be combinational:
- alu_ain = rf_treg1; alu_bin = rf_treg2 or rf_immediate.
- alu_op is 4 bits, decoded from rf_ir.
- ex_result <= ALU output, or ddin for LD.
REQ-014 EX memory access SHALL be combinational:
- LD: doe=1, daddr=rf_treg2.
- ST: dwe=1 for exactly one cycle, daddr=rf_treg2, ddout=rf_treg1.
- Otherwise doe=dwe=0.
REQ-015 WB: reg_file_we SHALL be 1 when ex_ir writes Rd (ALU ops, immediates, LD); ex_result is written to register ex_ir[10:8] at the rising edge.
REQ-016 RF operand reads SHALL forward the newest value, with priority EX result, then WB ex_result, then the register file, so back-to-back dependent instructions need no stall; this includes LD followed by a dependent instruction.
REQ-017 Branch resolution SHALL occur in EX:
- Taken: if_pc_we=1, if_pc<=target, if_ir and rf_ir replaced by 16'h0000 (two-slot squash).
- Not taken: if_pc<=if_pc+2.
REQ-018 A squashed slot SHALL produce no register write, no dwe, and no branch.
REQ-019 if_pc SHALL wrap from 16'hFFFE to 16'h0000.

Reset
REQ-020 While rst=1 at a clock edge, the following SHALL be set to 0: if_pc; if_ir, rf_ir and ex_ir (NOP); rf_pc; rf_treg1, rf_treg2 and rf_immediate; ex_result; r0..r7.
REQ-021 While rst=1, doe, dwe and reg_file_we SHALL be 0. Reset asserted mid-program SHALL discard all in-flight instructions.
REQ-022 The first fetch SHALL be from address 0 in the first cycle after rst falls.

Verification
REQ-023 LLI r1,0x12; LUI r2,0x34; OR r2,r1 back-to-back -> r2=0x3412 via forwarding, no stall.
REQ-024 LLI r1,0x00; LUI r1,0x02; LLI r3,0xAB; ST r3,r1; LD r4,r1 -> dwe one cycle with daddr=0x0200, ddout=0x00AB; then r4=0x00AB.
REQ-025 LLI r1,5; loop: ADDI r1,-1; BNEZ r1,loop -> exits with r1=0; the two instructions after each taken branch do not commit.
REQ-026 LLI r1,0xFF; ADDI r1,1 -> r1=0x0100. Then LUI r2,0x80; BMI r2,+4 -> branch taken, if_pc_we=1 for one cycle.
REQ-027 Assert rst during a program -> next cycle if_pc=0, registers 0, doe=dwe=0; restarting the program reproduces the first-run results.

Source files
------------

// File: rtl/risc16p.sv
// risc16p: four-stage IF/RF/EX/WB 16-bit RISC core with full operand forwarding and EX-stage branches
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [15:0] rd1,
  output logic [15:0] rd2
);
  logic [15:0] register0, register1, register2, register3;
  logic [15:0] register4, register5, register6, register7;
  logic [15:0] view [8];
  assign view = '{register0, register1, register2, register3, register4, register5, register6, register7};
  assign rd1 = view[ra1];
  assign rd2 = view[ra2];
  always_ff @(posedge clk) begin
    register0 <= rst ? 16'h0 : (we && wa == 3'd0) ? wd : register0;
    register1 <= rst ? 16'h0 : (we && wa == 3'd1) ? wd : register1;
    register2 <= rst ? 16'h0 : (we && wa == 3'd2) ? wd : register2;
    register3 <= rst ? 16'h0 : (we && wa == 3'd3) ? wd : register3;
    register4 <= rst ? 16'h0 : (we && wa == 3'd4) ? wd : register4;
    register5 <= rst ? 16'h0 : (we && wa == 3'd5) ? wd : register5;
    register6 <= rst ? 16'h0 : (we && wa == 3'd6) ? wd : register6;
    register7 <= rst ? 16'h0 : (we && wa == 3'd7) ? wd : register7;
  end
endmodule

module risc16p (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] iaddr,
  input  logic [15:0] idin,
  output logic        ioe,
  output logic [15:0] daddr,
  output logic [15:0] ddout,
  input  logic [15:0] ddin,
  output logic        doe,
  output logic        dwe
);
  typedef enum logic [3:0] {
    A_PASS, A_NOT, A_XOR, A_ADD, A_SUB, A_SL8, A_SR8, A_SL, A_SR, A_AND, A_OR
  } alu_op_t;
  logic [15:0] if_pc_q, if_pc_d, if_ir_q, if_ir_d, rf_pc_q, rf_pc_d, rf_ir_q, rf_ir_d;
  logic [15:0] rf_treg1_q, rf_treg1_d, rf_treg2_q, rf_treg2_d, rf_immediate_q, rf_immediate_d;
  logic [15:0] ex_pc_q, ex_pc_d, ex_ir_q, ex_ir_d, ex_result_q, ex_result_d;
  logic [15:0] rd_val, rs_val, alu_ain, alu_bin, alu_out, target;
  logic [4:0]  rf_op, ex_op, ex_fn;
  alu_op_t     alu_op;
  logic        ex_we, reg_file_we, is_ld, is_st, if_pc_we;

  function automatic logic writes_rd(input logic [15:0] ir);
    logic [4:0] f;
    f = ir[4:0];
    case (ir[15:11])
      5'b00000: writes_rd = f inside {5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01000,
                                      5'b01001, 5'b01100, 5'b01101, 5'b10000, 5'b10001, 5'b10101};
      5'b00001, 5'b00010, 5'b00100, 5'b00110, 5'b00111: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  endfunction

  reg_file reg_file_inst (
    .clk(clk), .rst(rst), .we(reg_file_we), .wa(ex_ir_q[10:8]), .wd(ex_result_q),
    .ra1(if_ir_q[10:8]), .ra2(if_ir_q[7:5]), .rd1(rd_val), .rd2(rs_val)
  );

  assign iaddr = if_pc_q;
  assign ioe   = ~rst;
  assign daddr = rf_treg2_q;
  assign ddout = rf_treg1_q;
  assign doe   = is_ld;
  assign dwe   = is_st;

  always_comb begin
    ex_op = rf_ir_q[15:11];
    ex_fn = rf_ir_q[4:0];
    alu_op = A_PASS;
    if (ex_op == 5'b00000)
      case (ex_fn)
        5'b00010: alu_op = A_NOT;
        5'b00011: alu_op = A_XOR;
        5'b00100: alu_op = A_ADD;
        5'b00101: alu_op = A_SUB;
        5'b01000: alu_op = A_SL8;
        5'b01001: alu_op = A_SR8;
        5'b01100: alu_op = A_SL;
        5'b01101: alu_op = A_SR;
        5'b10000: alu_op = A_AND;
        5'b10001: alu_op = A_OR;
        default:  alu_op = A_PASS;
      endcase
    else
      alu_op = ex_op == 5'b00100 ? A_ADD : ex_op == 5'b00110 ? A_AND : ex_op == 5'b00111 ? A_OR : A_PASS;
    alu_ain = rf_treg1_q;
    alu_bin = ex_op == 5'b00000 ? rf_treg2_q : rf_immediate_q;
    case (alu_op)
      A_NOT:   alu_out = ~alu_bin;
      A_XOR:   alu_out = alu_ain ^ alu_bin;
      A_ADD:   alu_out = alu_ain + alu_bin;
      A_SUB:   alu_out = alu_ain - alu_bin;
      A_SL8:   alu_out = alu_bin << 8;
      A_SR8:   alu_out = alu_bin >> 8;
      A_SL:    alu_out = alu_bin << 1;
      A_SR:    alu_out = alu_bin >> 1;
      A_AND:   alu_out = alu_ain & alu_bin;
      A_OR:    alu_out = alu_ain | alu_bin;
      default: alu_out = alu_bin;
    endcase
    is_ld = ~rst && ex_op == 5'b00000 && ex_fn == 5'b10101;
    is_st = ~rst && ex_op == 5'b00000 && ex_fn == 5'b10100;
    ex_we = writes_rd(rf_ir_q);
    reg_file_we = ~rst & writes_rd(ex_ir_q);
    ex_result_d = is_ld ? ddin : alu_out;
    target = ex_pc_q + 16'd2 + rf_immediate_q;
    if_pc_we = ~rst & (ex_op == 5'b11000 ? |rf_treg1_q : ex_op == 5'b11001 ? ~|rf_treg1_q :
                       ex_op == 5'b11010 ? rf_treg1_q[15] : ex_op == 5'b11011 ? ~rf_treg1_q[15] :
                       ex_op == 5'b11100);
    // a taken branch kills the instruction in RF and the one being fetched
    if_pc_d = if_pc_we ? target : if_pc_q + 16'd2;
    if_ir_d = if_pc_we ? 16'h0000 : idin;
    rf_ir_d = if_pc_we ? 16'h0000 : if_ir_q;
    rf_pc_d = if_pc_q;
    ex_pc_d = rf_pc_q;
    ex_ir_d = rf_ir_q;
    rf_op = if_ir_q[15:11];
    rf_immediate_d = rf_op == 5'b11100 ? {{5{if_ir_q[10]}}, if_ir_q[10:0]} :
                     rf_op == 5'b00010 ? {if_ir_q[7:0], 8'h00} :
                     (rf_op == 5'b00100 || rf_op[4:3] == 2'b11) ? {{8{if_ir_q[7]}}, if_ir_q[7:0]} :
                     {8'h00, if_ir_q[7:0]};
    rf_treg1_d = (ex_we && rf_ir_q[10:8] == if_ir_q[10:8]) ? ex_result_d :
                 (reg_file_we && ex_ir_q[10:8] == if_ir_q[10:8]) ? ex_result_q : rd_val;
    rf_treg2_d = (ex_we && rf_ir_q[10:8] == if_ir_q[7:5]) ? ex_result_d :
                 (reg_file_we && ex_ir_q[10:8] == if_ir_q[7:5]) ? ex_result_q : rs_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc_q        <= '0;
      if_ir_q        <= '0;
      rf_pc_q        <= '0;
      rf_ir_q        <= '0;
      rf_treg1_q     <= '0;
      rf_treg2_q     <= '0;
      rf_immediate_q <= '0;
      ex_pc_q        <= '0;
      ex_ir_q        <= '0;
      ex_result_q    <= '0;
    end else begin
      if_pc_q        <= if_pc_d;
      if_ir_q        <= if_ir_d;
      rf_pc_q        <= rf_pc_d;
      rf_ir_q        <= rf_ir_d;
      rf_treg1_q     <= rf_treg1_d;
      rf_treg2_q     <= rf_treg2_d;
      rf_immediate_q <= rf_immediate_d;
      ex_pc_q        <= ex_pc_d;
      ex_ir_q        <= ex_ir_d;
      ex_result_q    <= ex_result_d;
    end
  end
endmodule

// File: tb/tb_risc16p.sv
// tb_risc16p: random and directed programs checked against an instruction-level reference model
module tb_risc16p;
  localparam logic [15:0] HALT = 16'hE7FE;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] iaddr, idin, daddr, ddout, ddin;
  logic ioe, doe, dwe;
  logic [15:0] imem [32768];
  logic [15:0] dmem [32768];
  logic [15:0] dinit [32768];
  logic [15:0] mmem [32768];
  logic [15:0] mr [8];
  logic [31:0] st_q [$];
  logic [31:0] mst [$];
  logic        we_log [$];
  logic [4:0]  rfn [13] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd12, 5'd13, 5'd16, 5'd17, 5'd6, 5'd30};
  logic [4:0]  iops [5] = '{5'd4, 5'd6, 5'd7, 5'd1, 5'd2};
  logic [4:0]  uops [7] = '{5'd3, 5'd5, 5'd8, 5'd16, 5'd29, 5'd30, 5'd31};
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign idin = imem[iaddr[15:1]];
  assign ddin = dmem[daddr[15:1]];

  risc16p dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idin(idin), .ioe(ioe),
    .daddr(daddr), .ddout(ddout), .ddin(ddin), .doe(doe), .dwe(dwe)
  );

  always @(negedge clk)
    if (!rst) begin
      if (dwe) begin
        st_q.push_back({daddr, ddout});
        dmem[daddr[15:1]] = ddout;
      end
      we_log.push_back(dut.if_pc_we);
    end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [4:0] f, input int d, input int s);
    return {5'd0, 3'(d), 3'(s), f};
  endfunction

  function automatic logic [15:0] ri(input logic [4:0] op, input int d, input logic [7:0] imm);
    return {op, 3'(d), imm};
  endfunction

  function automatic logic [15:0] reg_of(input int i);
    case (i)
      0: return dut.reg_file_inst.register0;
      1: return dut.reg_file_inst.register1;
      2: return dut.reg_file_inst.register2;
      3: return dut.reg_file_inst.register3;
      4: return dut.reg_file_inst.register4;
      5: return dut.reg_file_inst.register5;
      6: return dut.reg_file_inst.register6;
      default: return dut.reg_file_inst.register7;
    endcase
  endfunction

  task automatic load(input logic [15:0] p [$]);
    for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
    foreach (p[i]) imem[i] = p[i];
  endtask

  task automatic run_prog(input int cycles);
    dmem = dinit;
    st_q.delete();
    we_log.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // sequential ISA interpreter: one instruction at a time, no pipeline
  task automatic model_run();
    logic [15:0] pc, ir, npc, s8, z8;
    logic [2:0] d, s;
    pc = 16'h0;
    mmem = dinit;
    mst.delete();
    for (int i = 0; i < 8; i++) mr[i] = 16'h0;
    for (int n = 0; n < 5000; n++) begin
      ir = imem[pc[15:1]];
      if (ir == HALT) break;
      d = ir[10:8];
      s = ir[7:5];
      s8 = {{8{ir[7]}}, ir[7:0]};
      z8 = {8'h00, ir[7:0]};
      npc = pc + 16'd2;
      case (ir[15:11])
        5'd0: case (ir[4:0])
          5'd1:  mr[d] = mr[s];
          5'd2:  mr[d] = ~mr[s];
          5'd3:  mr[d] = mr[d] ^ mr[s];
          5'd4:  mr[d] = mr[d] + mr[s];
          5'd5:  mr[d] = mr[d] - mr[s];
          5'd8:  mr[d] = mr[s] << 8;
          5'd9:  mr[d] = mr[s] >> 8;
          5'd12: mr[d] = mr[s] << 1;
          5'd13: mr[d] = mr[s] >> 1;
          5'd16: mr[d] = mr[d] & mr[s];
          5'd17: mr[d] = mr[d] | mr[s];
          5'd20: begin
            mst.push_back({mr[s], mr[d]});
            mmem[mr[s][15:1]] = mr[d];
          end
          5'd21: mr[d] = mmem[mr[s][15:1]];
          default: ;
        endcase
        5'd1:  mr[d] = z8;
        5'd2:  mr[d] = {ir[7:0], 8'h00};
        5'd4:  mr[d] = mr[d] + s8;
        5'd6:  mr[d] = mr[d] & z8;
        5'd7:  mr[d] = mr[d] | z8;
        5'd24: if (mr[d] != 16'h0) npc = pc + 16'd2 + s8;
        5'd25: if (mr[d] == 16'h0) npc = pc + 16'd2 + s8;
        5'd26: if (mr[d][15]) npc = pc + 16'd2 + s8;
        5'd27: if (!mr[d][15]) npc = pc + 16'd2 + s8;
        5'd28: npc = pc + 16'd2 + {{5{ir[10]}}, ir[10:0]};
        default: ;
      endcase
      pc = npc;
    end
  endtask

  task automatic compare_model(input string tag);
    model_run();
    for (int i = 0; i < 8; i++) check($sformatf("%s r%0d", tag, i), reg_of(i), mr[i]);
    check({tag, " store count"}, 16'(st_q.size()), 16'(mst.size()));
    for (int i = 0; i < st_q.size() && i < mst.size(); i++) begin
      check($sformatf("%s st%0d addr", tag, i), st_q[i][31:16], mst[i][31:16]);
      check($sformatf("%s st%0d data", tag, i), st_q[i][15:0], mst[i][15:0]);
    end
  endtask

  task automatic gen_prog(input int len);
    logic [15:0] p [$];
    int lim, off;
    for (int i = 0; i < len; i++) begin
      lim = 2 * (len - i - 1);
      if (lim > 126) lim = 126;
      off = 2 * int'($urandom_range(0, lim / 2));
      case ($urandom_range(0, 9))
        0, 1: p.push_back(rr(rfn[$urandom_range(0, 12)], $urandom_range(0, 7), $urandom_range(0, 7)));
        2, 3: p.push_back(ri(iops[$urandom_range(0, 4)], $urandom_range(0, 7), 8'($urandom)));
        4: p.push_back(rr(5'd20, $urandom_range(0, 7), $urandom_range(0, 7)));
        5: p.push_back(rr(5'd21, $urandom_range(0, 7), $urandom_range(0, 7)));
        6, 7: p.push_back(ri(5'(24 + $urandom_range(0, 3)), $urandom_range(0, 7), 8'(off)));
        8: p.push_back({5'd28, 11'(off)});
        default: p.push_back({uops[$urandom_range(0, 6)], 11'($urandom)});
      endcase
    end
    p.push_back(HALT);
    load(p);
  endtask

  initial begin
    logic [15:0] p [$];
    int pulses;
    for (int i = 0; i < 32768; i++) dinit[i] = 16'($urandom);
    load(p);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset iaddr", iaddr, 16'h0000);
    check("reset ioe", 16'(ioe), 16'h0);
    check("reset doe", 16'(doe), 16'h0);
    check("reset dwe", 16'(dwe), 16'h0);
    for (int i = 0; i < 8; i++) check($sformatf("reset r%0d", i), reg_of(i), 16'h0000);

    p = '{ri(5'd1, 1, 8'h12), ri(5'd2, 2, 8'h34), rr(5'd17, 2, 1), HALT};
    load(p);
    run_prog(20);
    check("fwd r2", reg_of(2), 16'h3412);
    compare_model("fwd");

    p = '{ri(5'd1, 1, 8'h00), ri(5'd2, 1, 8'h02), ri(5'd1, 3, 8'hAB), rr(5'd20, 3, 1), rr(5'd21, 4, 1), HALT};
    load(p);
    run_prog(20);
    check("st pulses", 16'(st_q.size()), 16'd1);
    if (st_q.size() > 0) begin
      check("st daddr", st_q[0][31:16], 16'h0200);
      check("st ddout", st_q[0][15:0], 16'h00AB);
    end
    check("ld r4", reg_of(4), 16'h00AB);
    compare_model("ldst");

    // reset while the store sits in EX: dwe drops at once and nothing survives the edge
    run_prog(5);
    rst = 1'b1;
    #1;
    check("mid rst dwe comb", 16'(dwe), 16'h0);
    @(posedge clk);
    #1;
    check("mid rst iaddr", iaddr, 16'h0000);
    check("mid rst doe", 16'(doe), 16'h0);
    check("mid rst dwe", 16'(dwe), 16'h0);
    for (int i = 0; i < 8; i++) check($sformatf("mid rst r%0d", i), reg_of(i), 16'h0000);
    run_prog(20);
    check("rerun st pulses", 16'(st_q.size()), 16'd1);
    if (st_q.size() > 0) check("rerun st daddr", st_q[0][31:16], 16'h0200);
    check("rerun r4", reg_of(4), 16'h00AB);

    p = '{ri(5'd1, 1, 8'h05), ri(5'd4, 1, 8'hFF), ri(5'd24, 1, 8'hFC), ri(5'd4, 2, 8'h01), ri(5'd4, 3, 8'h01), HALT};
    load(p);
    run_prog(60);
    check("loop r1", reg_of(1), 16'h0000);
    check("loop r2", reg_of(2), 16'h0001);
    check("loop r3", reg_of(3), 16'h0001);
    compare_model("loop");
    run_prog(9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i < 4; i++) check($sformatf("loop rst r%0d", i), reg_of(i), 16'h0000);
    run_prog(60);
    check("loop rerun r1", reg_of(1), 16'h0000);
    check("loop rerun r2", reg_of(2), 16'h0001);

    p = '{ri(5'd1, 1, 8'hFF), ri(5'd4, 1, 8'h01), ri(5'd2, 2, 8'h80), ri(5'd26, 2, 8'h04),
          ri(5'd1, 3, 8'h01), ri(5'd1, 3, 8'h02), ri(5'd1, 4, 8'h07), HALT};
    load(p);
    run_prog(30);
    check("addi r1", reg_of(1), 16'h0100);
    check("bmi skip r3", reg_of(3), 16'h0000);
    check("bmi r4", reg_of(4), 16'h0007);
    pulses = 0;
    for (int i = 0; i < 9 && i < we_log.size(); i++) pulses += int'(we_log[i]);
    check("bmi pc_we pulses", 16'(pulses), 16'd1);
    if (we_log.size() > 5) check("bmi pc_we cycle5", 16'(we_log[5]), 16'd1);
    compare_model("bmi");

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 32768; i++) dinit[i] = 16'($urandom);
      gen_prog(40);
      run_prog(140);
      compare_model($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
